shift_cmd_ctrl: RTL
===================

# shift_cmd_ctrl

Command-driven sequencer for an N-bit universal shift datapath. Accepts one command per valid/ready handshake (clear, load, shift-left by k, shift-right by k), drives the shift datapath's mode select cycle by cycle, counts shift steps and pulses `done` on completion. Sits between a host/FSM issuing word-level operations and the shift register, and replaces hand-driven mode codes with a counted, handshaked interface.

## Interface
- `N`, 8: datapath width in bits, minimum 2.
- `CW`, `$clog2(N+1)`: width of the shift-count field.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  00 CLR, 01 SHL, 10 SHR, 11 LOAD.
- `cmd_cnt`  in  CW  number of shift steps for SHL/SHR; ignored for CLR/LOAD.
- `cmd_data`  in  N  parallel load value for LOAD.
- `ser_in`  in  1  fill bit, sampled at every shift edge.
- `ser_out`  out  1  outgoing bit: `q[N-1]` if last accepted shift op was SHL, else `q[0]`.
- `q`  out  N  register contents.
- `busy`  out  1  multi-cycle shift in progress.
- `done`  out  1  one-cycle completion pulse per accepted command.

## Operation
- States: IDLE, SHIFT. `cmd_ready` = (state == IDLE) and not `rst`. `busy` = (state == SHIFT).
- Handshake: command accepted on an edge where `cmd_valid && cmd_ready`. Inputs are sampled only at acceptance; `cmd_valid` held while not ready causes no action.
- CLR: `q` ← 0 at the accept edge; stay IDLE; `done` high the next cycle.
- LOAD: `q` ← `cmd_data` at the accept edge; stay IDLE; `done` high the next cycle.
- SHL/SHR with `cmd_cnt` = 0: `q` unchanged, stay IDLE, `done` high the next cycle; direction for `ser_out` still updated.
- SHL/SHR with `cmd_cnt` = c > 0: at accept edge latch direction, remaining ← c, go SHIFT, `q` unchanged. Each SHIFT edge: SHL `q` ← {q[N-2:0], fill}, SHR `q` ← {fill, q[N-1:1]}; remaining decrements. Edge where remaining == 1 performs the last shift and returns to IDLE.
- c > N is legal: shifts c times (register ends fully filled with sampled fill bits).
- Reset: `q` = 0, state IDLE, remaining 0, direction = SHR (so `ser_out` = 0), `done` = 0, `busy` = 0, `cmd_ready` = 0 while `rst` high, 1 the cycle after. Reset mid-shift aborts; no `done` issued for the aborted command.

## Timing
- CLR/LOAD/zero-count: accept at E0; `q` new after E0; `done` high for the cycle after E0; `cmd_ready` stays high, so back-to-back commands are accepted every cycle.
- Shift by c: accept E0; shifts at E1..Ec; `busy` high for cycles after E0 through before Ec; `done` and `cmd_ready` both high in the cycle after Ec. Throughput: c+1 edges per command.
- `done` is registered; `ser_out` is combinational from `q` and registered direction.

## Configuration
- `SHIFT_ROT_EN` defined: adds input `cmd_rot` (1 bit, sampled at acceptance). When 1, the fill bit at every shift edge is the bit shifted out (rotate) instead of `ser_in`; ignored for CLR/LOAD.
- Not defined: `cmd_rot` port absent; fill bit is always `ser_in`.

## Structure
- Package `shift_ctrl_pkg`: enum `op_e` (OP_CLR=2'b00, OP_SHL=2'b01, OP_SHR=2'b10, OP_LOAD=2'b11), enum `state_e` (IDLE, SHIFT).
- Sub-module `shift_core`: N-bit register with 2-bit mode mux (hold/left/right/load), fill bit input, synchronous active-high reset; controller drives its mode, fill and load data.

## Test plan
- N=8: LOAD 8'hA5 → `q`=8'hA5 one edge after accept, `done` one cycle, `busy` never high.
- From 8'hA5, SHL cnt=3 ser_in=1 → `q`=8'h2F after 4 edges from accept, `busy` 3 cycles, single `done`.
- From 8'hA5, SHR cnt=2 ser_in=0 → `q`=8'h29, `ser_out`=`q[0]`; then SHL cnt=0 → `q` unchanged, `done` next cycle.
- Hold `cmd_valid` with LOAD 8'hFF during SHL cnt=4 → not accepted until `cmd_ready`, then `q`=8'hFF; exactly two `done` pulses.
- Assert `rst` at 2nd shift edge of SHR cnt=5 → `q`=0, IDLE, no `done`, `cmd_ready` back after release.
- With `SHIFT_ROT_EN`: from 8'h81, SHL cnt=1 `cmd_rot`=1 → `q`=8'h03; SHR cnt=1 `cmd_rot`=1 from 8'h03 → 8'h81.

Source files
------------

// File: rtl/shift_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared types for the shift command controller and its shift datapath.
//   op_e    : host command opcodes carried on cmd_op
//   state_e : controller states (IDLE accepts commands, SHIFT steps the core)
//   mode_e  : mode select driven into shift_core each cycle
// ---------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_cmd_ctrl_core.sv
// ---------------------------------------------------------------------------
// shift_core
// N-bit universal shift register with a 2-bit mode mux.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears the register
//   i_mode     : hold / shift left / shift right / parallel load
//   i_fill     : bit entering the vacated end on a shift
//   i_loadData : parallel load value used in MODE_LOAD
//   o_q        : register contents
// ---------------------------------------------------------------------------
module shift_core
  import shift_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  mode_e        i_mode,
  input  logic         i_fill,
  input  logic [N-1:0] i_loadData,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // The register itself: left shift brings the fill bit in at bit 0,
  // right shift brings it in at bit N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      case (i_mode)
        MODE_LEFT:  r_q <= {r_q[N-2:0], i_fill};
        MODE_RIGHT: r_q <= {i_fill, r_q[N-1:1]};
        MODE_LOAD:  r_q <= i_loadData;
        default:    r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// shift_cmd_ctrl
// Command-driven sequencer for an N-bit universal shift datapath. One command
// is accepted per valid/ready handshake; shift commands are stepped one bit
// per cycle and every accepted command produces a single done pulse.
// Optional feature macro: SHIFT_ROT_EN adds cmd_rot, selecting rotate instead
// of ser_in as the fill bit for shift commands.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : controller idle and able to accept
//   cmd_op     : 00 CLR, 01 SHL, 10 SHR, 11 LOAD
//   cmd_cnt    : shift step count for SHL/SHR
//   cmd_data   : parallel load value for LOAD
//   cmd_rot    : (SHIFT_ROT_EN only) rotate instead of using ser_in
//   ser_in     : fill bit sampled at every shift edge
//   ser_out    : q[N-1] after a left-shift command, else q[0]
//   q          : register contents
//   busy       : multi-cycle shift in progress
//   done       : one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_cmd_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [N-1:0]  cmd_data,
`ifdef SHIFT_ROT_EN
  input  logic          cmd_rot,
`endif
  input  logic          ser_in,
  output logic          ser_out,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        r_state;
  state_e        w_stateNext;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] w_remNext;
  logic          r_dirLeft;
  logic          w_dirLeftNext;
  logic          r_done;
  logic          w_doneNext;
  logic          w_accept;
  logic          w_fill;
  mode_e         w_mode;
  logic [N-1:0]  w_loadData;
  logic [N-1:0]  w_q;
  op_e           w_op;

  assign w_op     = op_e'(cmd_op);
  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept = cmd_valid && cmd_ready;

`ifdef SHIFT_ROT_EN
  logic r_rot;
  logic w_rotNext;

  // Rotating feeds back the bit that is about to leave the register.
  assign w_fill = r_rot ? (r_dirLeft ? w_q[N-1] : w_q[0]) : ser_in;
`else
  assign w_fill = ser_in;
`endif

  // Controller state: all registered bookkeeping lives here. Reset leaves the
  // direction at "right" so ser_out starts out as q[0] = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_dirLeft <= 1'b0;
      r_done    <= 1'b0;
`ifdef SHIFT_ROT_EN
      r_rot     <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_rem     <= w_remNext;
      r_dirLeft <= w_dirLeftNext;
      r_done    <= w_doneNext;
`ifdef SHIFT_ROT_EN
      r_rot     <= w_rotNext;
`endif
    end
  end

  // Next-state and datapath control. CLR is a parallel load of zero, so the
  // core only needs its load path for both CLR and LOAD. A zero-count shift
  // completes immediately but still records its direction for ser_out.
  always_comb begin
    w_stateNext   = r_state;
    w_remNext     = r_rem;
    w_dirLeftNext = r_dirLeft;
    w_doneNext    = 1'b0;
    w_mode        = MODE_HOLD;
    w_loadData    = cmd_data;
`ifdef SHIFT_ROT_EN
    w_rotNext     = r_rot;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_CLR: begin
              w_mode     = MODE_LOAD;
              w_loadData = '0;
              w_doneNext = 1'b1;
            end
            OP_LOAD: begin
              w_mode     = MODE_LOAD;
              w_doneNext = 1'b1;
            end
            default: begin
              w_dirLeftNext = (w_op == OP_SHL);
`ifdef SHIFT_ROT_EN
              w_rotNext     = cmd_rot;
`endif
              if (cmd_cnt == '0) begin
                w_doneNext = 1'b1;
              end else begin
                w_stateNext = SHIFT;
                w_remNext   = cmd_cnt;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        w_mode    = r_dirLeft ? MODE_LEFT : MODE_RIGHT;
        w_remNext = r_rem - CNT_ONE;
        if (r_rem == CNT_ONE) begin
          w_stateNext = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  shift_core #(
    .N(N)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_mode     (w_mode),
    .i_fill     (w_fill),
    .i_loadData (w_loadData),
    .o_q        (w_q)
  );

  assign q       = w_q;
  assign ser_out = r_dirLeft ? w_q[N-1] : w_q[0];
  assign busy    = (r_state == SHIFT);
  assign done    = r_done;

endmodule
